// File: rtl/cond_pkg.sv
// Shared definitions for the branch-condition unit and its future users
// (e.g. the predicated-execution unit).
//   cond_t      : 8-bit condition code
//   COND_*      : bit positions inside a condition code
//   FLAG_*      : bit positions inside the stored {V,C,N,Z} flag vector
package cond_pkg;

  localparam int unsigned COND_Z    = 0;
  localparam int unsigned COND_N    = 1;
  localparam int unsigned COND_INV  = 2;
  localparam int unsigned COND_C    = 3;
  localparam int unsigned COND_V    = 4;
  localparam int unsigned COND_LT   = 5;
  localparam int unsigned COND_LOOP = 6;
  localparam int unsigned COND_LIVE = 7;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef logic [7:0] cond_t;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition evaluator.
// Ports:
//   cond    : condition code (test enables, invert, live bit ignored here)
//   z,n,c,v : already-selected flag sources
//   loop_nz : loop counter is non-zero
//   result  : OR of enabled tests, optionally inverted
module cond_eval
  import cond_pkg::*;
(
  input  cond_t cond,
  input  logic  z,
  input  logic  n,
  input  logic  c,
  input  logic  v,
  input  logic  loop_nz,
  output logic  result
);

  logic raw;

  always_comb begin
    raw = (cond[COND_Z]    & z)
        | (cond[COND_N]    & n)
        | (cond[COND_C]    & c)
        | (cond[COND_V]    & v)
        | (cond[COND_LT]   & (n ^ v))
        | (cond[COND_LOOP] & loop_nz);
    result = raw ^ cond[COND_INV];
  end

  // Live bit selects sources upstream; it has no role in the evaluation itself.
  logic unused_live;
  assign unused_live = cond[COND_LIVE];

endmodule

// File: rtl/cond_flags_unit.sv
// Branch-condition unit: stored Z/N/C/V flags, hardware loop counter and a
// single-entry registered valid/ready output carrying the branch decision.
// Ports:
//   clk, rst                  : clock, async active-low reset
//   flag_we, alu_result,
//   alu_carry, alu_ovf        : flag capture from the ALU
//   loop_load, loop_value     : loop counter load
//   in_valid/in_ready, cond,
//   live_op                   : evaluation request
//   out_valid/out_ready,
//   result                    : registered branch decision
//   flags, loop_cnt           : debug/status views of the state
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          LOOP_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_we,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_ovf,
  input  logic                 loop_load,
  input  logic [CNT_WIDTH-1:0] loop_value,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  cond_t                cond,
  input  logic [WIDTH-1:0]     live_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 result,
  output logic [3:0]           flags,
  output logic [CNT_WIDTH-1:0] loop_cnt
);

  logic [3:0]           flags_q;
  logic [CNT_WIDTH-1:0] loop_q;
  logic                 out_valid_q;
  logic                 result_q;

  logic accept;
  logic live;
  logic z_sel, n_sel, c_sel, v_sel;
  logic loop_nz;
  logic eval_result;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign live     = cond[COND_LIVE];
  assign loop_nz  = LOOP_EN && (loop_q != '0);

  // Live mode bypasses the stored flags; C and V have no live source.
  always_comb begin
    z_sel = live ? (live_op == '0)       : flags_q[FLAG_Z];
    n_sel = live ? live_op[WIDTH-1]      : flags_q[FLAG_N];
    c_sel = live ? 1'b0                  : flags_q[FLAG_C];
    v_sel = live ? 1'b0                  : flags_q[FLAG_V];
  end

  cond_eval u_eval (
    .cond    (cond),
    .z       (z_sel),
    .n       (n_sel),
    .c       (c_sel),
    .v       (v_sel),
    .loop_nz (loop_nz),
    .result  (eval_result)
  );

  // Evaluation reads flags_q before this edge, so a same-cycle capture
  // only affects later requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q[FLAG_Z] <= (alu_result == '0);
      flags_q[FLAG_N] <= alu_result[WIDTH-1];
      flags_q[FLAG_C] <= alu_carry;
      flags_q[FLAG_V] <= alu_ovf;
    end
  end

  // Load has priority over the decrement; decrement only when non-zero so
  // the counter saturates at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_q <= '0;
    end else if (LOOP_EN) begin
      if (loop_load) begin
        loop_q <= loop_value;
      end else if (accept && cond[COND_LOOP] && loop_nz) begin
        loop_q <= loop_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= eval_result;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign loop_cnt  = loop_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit (WIDTH=8, CNT_WIDTH=8, LOOP_EN=1).
module tb_cond_flags_unit;
  import cond_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_ovf;
  logic       loop_load;
  logic [7:0] loop_value;
  logic       in_valid;
  logic       in_ready;
  cond_t      cond;
  logic [7:0] live_op;
  logic       out_valid;
  logic       out_ready;
  logic       result;
  logic [3:0] flags;
  logic [7:0] loop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic sb[$];
  logic exp_res;

  always #5 clk = ~clk;

  cond_flags_unit #(
    .WIDTH     (8),
    .CNT_WIDTH (8),
    .LOOP_EN   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .loop_load  (loop_load),
    .loop_value (loop_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cond       (cond),
    .live_op    (live_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags),
    .loop_cnt   (loop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request; expected result is pushed when the accept is certain.
  task automatic send(input logic [7:0] c, input logic [7:0] op, input logic exp);
    bit got = 0;
    in_valid = 1'b1;
    cond     = c;
    live_op  = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_res = sb.pop_front();
        check("result", {31'd0, result}, {31'd0, exp_res});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    flag_we    = 1'b0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    loop_load  = 1'b0;
    loop_value = '0;
    in_valid   = 1'b0;
    cond       = '0;
    live_op    = '0;
    out_ready  = 1'b1;

    // Reset state
    #12;
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_loop", {24'd0, loop_cnt}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {31'd0, result}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);

    // Legacy equivalence in live mode, back-to-back
    send(8'h81, 8'h00, 1'b1);
    send(8'h83, 8'h80, 1'b1);
    send(8'h87, 8'h05, 1'b1);
    send(8'h85, 8'h00, 1'b0);
    send(8'h00, 8'h00, 1'b0);
    send(8'h04, 8'h00, 1'b1);

    // Stored flags: 0x7F, carry, ovf -> {V,C,N,Z} = 1100
    flag_we    = 1'b1;
    alu_result = 8'h7F;
    alu_carry  = 1'b1;
    alu_ovf    = 1'b1;
    tick(1);
    flag_we = 1'b0;
    check("flags_1100", {28'd0, flags}, 32'hC);
    send(8'h08, 8'h00, 1'b1);
    send(8'h20, 8'h00, 1'b1);
    send(8'h01, 8'h00, 1'b0);  // live_op=0 must be ignored outside live mode

    // Same-cycle capture: evaluation sees the old Z=0
    flag_we    = 1'b1;
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    send(8'h01, 8'h00, 1'b0);
    flag_we = 1'b0;
    send(8'h01, 8'h00, 1'b1);
    check("flags_0001", {28'd0, flags}, 32'h1);

    // Loop counter: 3 -> results 1,1,1,0 with saturation
    loop_load  = 1'b1;
    loop_value = 8'd3;
    tick(1);
    loop_load = 1'b0;
    check("loop_load3", {24'd0, loop_cnt}, 32'd3);
    send(8'h40, 8'h00, 1'b1);
    check("loop_2", {24'd0, loop_cnt}, 32'd2);
    send(8'h40, 8'h00, 1'b1);
    check("loop_1", {24'd0, loop_cnt}, 32'd1);
    send(8'h40, 8'h00, 1'b1);
    check("loop_0", {24'd0, loop_cnt}, 32'd0);
    send(8'h40, 8'h00, 1'b0);
    check("loop_sat", {24'd0, loop_cnt}, 32'd0);

    // Load plus accepted loop test: test uses old count (1), load wins
    loop_load  = 1'b1;
    loop_value = 8'd1;
    tick(1);
    loop_value = 8'd7;
    send(8'h40, 8'h00, 1'b1);
    loop_load = 1'b0;
    check("load_wins", {24'd0, loop_cnt}, 32'd7);
    send(8'h01, 8'h00, 1'b1);
    check("no_loop_req", {24'd0, loop_cnt}, 32'd7);
    tick(3);

    // Backpressure
    out_ready = 1'b0;
    send(8'h04, 8'h00, 1'b1);
    in_valid = 1'b1;
    cond     = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", {31'd0, result}, 32'd1);
      check("bp_loop", {24'd0, loop_cnt}, 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h40, 8'h00, 1'b1);
    check("bp_loop_dec", {24'd0, loop_cnt}, 32'd6);
    tick(3);
    check("drained_valid", {31'd0, out_valid}, 32'd0);

    // Async reset mid-stall
    loop_load  = 1'b1;
    loop_value = 8'd5;
    tick(1);
    loop_load = 1'b0;
    out_ready = 1'b0;
    send(8'h04, 8'h00, 1'b1);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_loop", {24'd0, loop_cnt}, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", {31'd0, result}, 32'd0);
    check("arst_loop", {24'd0, loop_cnt}, 32'd0);
    check("arst_flags", {28'd0, flags}, 32'd0);
    sb.delete();  // pending output dropped by reset
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    send(8'h81, 8'h00, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    tick(1);
    check("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Parametrised successor to the 8-bit branch-condition evaluator in the ECP8 control path.
- Stores Z/N/C/V flags, captured from the ALU on request, and keeps a hardware loop counter.
- Evaluates an 8-bit condition code against either the stored flags or a live operand.
- Delivers a 1-bit branch decision through a registered valid/ready output stage to the sequencer.

Parameters:
- WIDTH, 8, data width of the ALU result and live operand (>=2).
- CNT_WIDTH, 8, loop counter width.
- LOOP_EN, 1, 0 removes the loop counter; the loop test then always reads false.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- flag_we  in  1  capture flags from alu_result/alu_carry/alu_ovf this cycle.
- alu_result  in  WIDTH  ALU result used for the Z/N capture.
- alu_carry  in  1  carry flag source.
- alu_ovf  in  1  overflow flag source.
- loop_load  in  1  load the loop counter.
- loop_value  in  CNT_WIDTH  loop counter load value.
- in_valid  in  1  evaluation request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- cond  in  8  condition code, sampled on accept.
- live_op  in  WIDTH  live operand for live mode, sampled on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- result  out  1  branch decision.
- flags  out  4  stored {V,C,N,Z}, for debug and the status register.
- loop_cnt  out  CNT_WIDTH  current loop counter value.

Behaviour:
- Reset (rst low, asynchronous): flags=0, loop_cnt=0, out_valid=0, result=0. Release is synchronised by the standard reset synchroniser upstream.
- Condition bits:
  - b0 = Z test.
  - b1 = N test.
  - b2 = invert.
  - b3 = C test.
  - b4 = V test.
  - b5 = signed-LT test (N^V).
  - b6 = loop test.
  - b7 = live mode.
- Sources in live mode (b7=1): Z = (live_op==0), N = live_op[WIDTH-1]; C and V are forced 0. Otherwise all four come from the stored flags.
- Compatibility: b0..b2 give exactly the legacy 8-bit evaluator result when b7=1 and WIDTH=8.
- raw = OR of the enabled tests; result = raw ^ b2.
  - cond=0x00 gives result 0; cond=0x04 gives result 1 (always).
- Flag capture on flag_we: Z = (alu_result==0), N = alu_result[WIDTH-1], C = alu_carry, V = alu_ovf.
- Loop test: true iff loop_cnt != 0 at the accept edge.
  - If it is true, loop_cnt decrements by 1 on that accept.
  - At 0 it saturates at 0; it never wraps to all-ones.
  - A request without b6 never changes loop_cnt.
- Handshake:
  - in_ready = !out_valid || out_ready, i.e. a single-entry output register.
  - Latency is 1 cycle: accept at edge k, out_valid/result visible after edge k.
  - Full throughput when out_ready is held high.
  - out_valid is held and result is stable while out_valid && !out_ready.
  - When no new accept occurs, out_valid clears on the edge where out_ready=1.
- Simultaneous events:
  - flag_we plus accept in the same cycle: evaluation uses the flags from before the edge; the new flags apply from the next request. Live mode is the bypass.
  - loop_load plus an accepted loop test: the test uses the pre-load count; the load wins over the decrement.
  - loop_load with no request: the counter loads and nothing else changes.
- Reset mid-operation: any pending output is dropped (out_valid=0). No partial decrement survives.
- Width: the counter is CNT_WIDTH unsigned; loop_value is loaded unmodified.

Decomposition:
- Shared package cond_pkg holds:
  - condition bit-index constants (COND_Z=0 ... COND_LIVE=7);
  - flag index constants (FLAG_Z..FLAG_V);
  - an 8-bit cond_t typedef.
- Sub-module cond_eval: purely combinational.
  - Inputs: cond, the selected Z/N/C/V, loop_nz.
  - Output: result.
  - Reusable by the future predicated-execution unit.
- The top level holds the flag register, the loop counter and the output register/handshake.

Test Plan:
- Legacy equivalence, WIDTH=8, live mode: cond=0x81 with live_op=0x00 -> result 1; cond=0x83 with live_op=0x80 -> 1; cond=0x87 with live_op=0x05 -> 1; cond=0x85 with live_op=0x00 -> 0.
- Stored flags: flag_we with alu_result=0x7F, carry=1, ovf=1; next cycle cond=0x08 -> 1, cond=0x20 -> 1 (N=0, V=1), cond=0x01 -> 0. flags reads 4'b1100.
- Same-cycle hazard: flags Z=0, then flag_we with alu_result=0 together with an accept of cond=0x01 -> result 0; the following request -> result 1.
- Loop: loop_load 3, then four back-to-back cond=0x40 requests -> results 1,1,1,0 and loop_cnt 2,1,0,0. No wrap past 0.
- Backpressure: hold out_ready=0 for 3 cycles after an accept -> in_ready=0, result stable, second request not accepted and loop_cnt unchanged; out_ready=1 -> second request accepted that cycle.
- Async reset asserted mid-stall with loop_cnt=5 and out_valid=1 -> all outputs read 0 immediately, without waiting for a clock edge.
